res_display_mux: RTL and testbench
==================================

RES_DISPLAY_MUX -- requirements
Module: res_display_mux

Interface
REQ-001 Parameter DIV, default 50000, meaning clock cycles per displayed digit (refresh slot); legal range 2..2^20.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 load  input  1  capture strobe; when high at a rising edge, So/flag/Sel are sampled.
REQ-005 So  input  4  raw 4-bit sum/difference from the upstream add/sub stage.
REQ-006 flag  input  1  upstream carry (Sel=0) or borrow (Sel=1).
REQ-007 Sel  input  1  upstream operation: 0 = A+B, 1 = A-B.
REQ-008 seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-009 an  output  3  digit enables, active-low, one-hot-low: an[0] units, an[1] tens, an[2] sign.
REQ-010 shown  output  1  high once at least one load has been captured since reset.

Function
REQ-011 On load=1, the block SHALL register sign and 5-bit magnitude in the same edge; otherwise the stored value SHALL hold.
REQ-012 Sel=0: magnitude = {flag,So} (0..31, reachable 0..30), sign positive.
REQ-013 Sel=1, flag=0: magnitude = So, sign positive; Sel=1, flag=1: magnitude = (~So+1) mod 16 (1..15), sign negative.
REQ-014 Stored magnitude SHALL be split into tens (0..3) and units (0..9) BCD digits; conversion is combinational from the stored register.
REQ-015 A refresh counter SHALL count 0..DIV-1 and wrap; on each wrap the digit index SHALL advance 0->1->2->0.
REQ-016 an and seg SHALL be a combinational decode of the digit index and stored value only (no direct path from So/flag/Sel); a captured value appears on the outputs the cycle after the load edge.
REQ-017 Exactly one an bit SHALL be low at all times after reset release; no all-off cycle.
REQ-018 Sign digit: negative -> seg=7'b0111111 (g only); positive -> blank 7'b1111111.
REQ-019 Digits 0..9 SHALL use standard 7-segment codes; codes 10..15 SHALL never be produced and SHALL decode to blank.
REQ-020 load asserted on a refresh-wrap edge: the index advance and the value capture SHALL both take effect on that edge.
REQ-021 load held high for consecutive cycles SHALL recapture every cycle (last value wins).

Reset
REQ-022 While rst_n=0: counter=0, digit index=0, stored magnitude=0, sign positive, shown=0; hence an=3'b110, seg=7'b1000000.
REQ-023 Reset asserted mid-slot SHALL clear immediately (asynchronous); counting restarts from 0 on the first edge after release.

Configuration
REQ-024 Macro LEADING_ZERO_BLANK_EN defined: tens digit SHALL display blank (7'b1111111) when tens=0; undefined: tens=0 displays "0" (7'b1000000). Units digit is never blanked.

Structure
REQ-025 A shared package SHALL hold the segment constants (SEG_BLANK, SEG_MINUS, digit codes 0..9) and the digit-index encoding.
REQ-026 The BCD-to-7-segment decode SHALL be a sub-module bcd7seg (4-bit in, 7-bit active-low out), instantiated once and fed by a digit-select mux.

Verification (DIV=4 for simulation)
REQ-027 Reset release, no load -> an cycles 110,101,011,110 every 4 clocks; seg 0 on units; tens shows 0 (blank with LEADING_ZERO_BLANK_EN); sign blank; shown=0.
REQ-028 load with Sel=0, flag=1, So=4'hE -> value 30: units slot seg "0", tens slot seg "3", sign blank; shown=1 the cycle after load.
REQ-029 load with Sel=1, flag=1, So=4'hB (3-8) -> units "5", tens "0"/blank, sign slot seg=7'b0111111.
REQ-030 load with Sel=1, flag=0, So=4'h9 -> units "9", sign blank; then load asserted exactly on a wrap edge with So=4'h2 -> next slot shows new value, index advances normally.
REQ-031 rst_n pulled low mid-slot while an=3'b011 -> an=3'b110, seg=7'b1000000, shown=0 without waiting for a clock edge.
REQ-032 Continuous check across all scenarios: an always has exactly one zero bit after reset; seg never shows a code outside {0..9, minus, blank}.

Source files
------------

// File: rtl/res_display_mux_pkg.sv
// res_display_mux_pkg: segment codes and digit-index encoding for the result display mux
package res_display_mux_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  typedef enum logic [1:0] {DIG_UNITS, DIG_TENS, DIG_SIGN} dig_t;
endpackage

// File: rtl/res_display_mux_bcd7seg.sv
// bcd7seg: BCD digit to active-low {g,f,e,d,c,b,a}; codes 10..15 blank
module bcd7seg
  import res_display_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);
  always_comb begin
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/res_display_mux.sv
// res_display_mux: captures add/sub result, multiplexes sign/tens/units onto a 3-digit display
// Option: LEADING_ZERO_BLANK_EN blanks the tens digit when it is zero.
module res_display_mux
  import res_display_mux_pkg::*;
#(
  parameter int DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] So,
  input  logic       flag,
  input  logic       Sel,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       shown
);
  localparam int CW = $clog2(DIV);
  logic [CW-1:0] cnt;
  dig_t idx;
  logic [4:0] mag, cap, rem;
  logic neg, wrap;
  logic [1:0] tens;
  logic [3:0] tens_code, code;
  logic [6:0] dseg;
  always_comb begin
    cap = Sel ? (flag ? {1'b0, ~So + 4'd1} : {1'b0, So}) : {flag, So};
    wrap = cnt == CW'(DIV - 1);
    tens = mag >= 5'd30 ? 2'd3 : mag >= 5'd20 ? 2'd2 : mag >= 5'd10 ? 2'd1 : 2'd0;
    rem = mag - 5'(tens) * 5'd10;
`ifdef LEADING_ZERO_BLANK_EN
    tens_code = tens == 2'd0 ? 4'hF : {2'b00, tens};
`else
    tens_code = {2'b00, tens};
`endif
    code = idx == DIG_UNITS ? rem[3:0] : tens_code;
    seg = idx == DIG_SIGN ? (neg ? SEG_MINUS : SEG_BLANK) : dseg;
    an = ~(3'b001 << idx);
  end
  bcd7seg u_dec (.bcd(code), .seg(dseg));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= DIG_UNITS;
      mag <= '0;
      neg <= 1'b0;
      shown <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      if (wrap) idx <= idx == DIG_SIGN ? DIG_UNITS : dig_t'(idx + 2'd1);
      if (load) begin
        mag <= cap;
        neg <= Sel & flag;
        shown <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_res_display_mux.sv
// tb_res_display_mux: directed checks of capture, refresh rotation, reset and segment legality
module tb_res_display_mux;
  logic clk, rst_n, load, flag, Sel;
  logic [3:0] So;
  logic [6:0] seg;
  logic [2:0] an;
  logic shown;
  int errors = 0, checks = 0;
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [6:0] T0 = 7'h7F;
`else
  localparam logic [6:0] T0 = 7'h40;
`endif
  res_display_mux #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .So(So), .flag(flag), .Sel(Sel),
    .seg(seg), .an(an), .shown(shown)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic seg_ok(input logic [6:0] s);
    case (s)
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h7F, 7'h3F: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction
  always @(negedge clk) begin
    check("an_onehot", $countones(~an), 1);
    check("seg_legal", seg_ok(seg), 1);
  end
  task automatic to_slot(input string tag, input logic [2:0] a);
    int n = 0;
    while (an !== a && n < 16) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_slot"}, an, a);
  endtask
  task automatic do_load(input logic s, input logic f, input logic [3:0] v);
    @(negedge clk);
    load = 1; Sel = s; flag = f; So = v;
    @(negedge clk);
    load = 0;
  endtask
  // sel, flag, So, expected units / tens / sign segments
  logic       t_sel [8] = '{0, 1, 0, 0, 0, 1, 1, 1};
  logic       t_flg [8] = '{1, 1, 0, 1, 0, 1, 1, 0};
  logic [3:0] t_so  [8] = '{4'hE, 4'hB, 4'h7, 4'h2, 4'hE, 4'hA, 4'hF, 4'h9};
  logic [6:0] t_u   [8] = '{7'h40, 7'h12, 7'h78, 7'h00, 7'h19, 7'h02, 7'h79, 7'h10};
  logic [6:0] t_t   [8] = '{7'h30, T0, T0, 7'h79, 7'h79, T0, T0, T0};
  logic [6:0] t_s   [8] = '{7'h7F, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h3F, 7'h7F};
  initial begin
    rst_n = 0; load = 0; Sel = 0; flag = 0; So = 0;
    #2;
    check("rst_an", an, 3'b110);
    check("rst_seg", seg, 7'h40);
    check("rst_shown", shown, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int k = 1; k <= 12; k++) begin
      logic [2:0] ea;
      logic [6:0] es;
      @(negedge clk);
      ea = (k / 4) % 3 == 0 ? 3'b110 : (k / 4) % 3 == 1 ? 3'b101 : 3'b011;
      es = (k / 4) % 3 == 0 ? 7'h40 : (k / 4) % 3 == 1 ? T0 : 7'h7F;
      check("idle_an", an, ea);
      check("idle_seg", seg, es);
      check("idle_shown", shown, 0);
    end
    for (int i = 0; i < 8; i++) begin
      do_load(t_sel[i], t_flg[i], t_so[i]);
      check("load_shown", shown, 1);
      to_slot("units", 3'b110);
      check($sformatf("units%0d", i), seg, t_u[i]);
      to_slot("tens", 3'b101);
      check($sformatf("tens%0d", i), seg, t_t[i]);
      to_slot("sign", 3'b011);
      check($sformatf("sign%0d", i), seg, t_s[i]);
    end
    to_slot("pre_wrap_t", 3'b101);
    to_slot("pre_wrap_s", 3'b011);
    repeat (3) @(negedge clk);
    check("before_wrap_an", an, 3'b011);
    load = 1; Sel = 1; flag = 0; So = 4'h2;
    @(negedge clk);
    load = 0;
    check("wrap_an", an, 3'b110);
    check("wrap_seg", seg, 7'h24);
    to_slot("mid", 3'b011);
    #2 rst_n = 0;
    #1;
    check("async_an", an, 3'b110);
    check("async_seg", seg, 7'h40);
    check("async_shown", shown, 0);
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    check("restart_units", an, 3'b110);
    @(negedge clk);
    check("restart_tens", an, 3'b101);
    check("restart_tseg", seg, T0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
